// File: rtl/dpbuf_fifo.sv
// Single-clock FIFO: block-RAM storage, registered read data, registered status flags.
// Optional sticky overflow/underflow flags are enabled by defining DPBUF_FIFO_ERR_FLAGS_EN.
module dpbuf_fifo #(
   parameter int unsigned ADDR_WDTH  = 4,
   parameter int unsigned DATA_WDTH  = 8,
   parameter int unsigned AFULL_THR  = (2 ** ADDR_WDTH) - 2,
   parameter int unsigned AEMPTY_THR = 2
) (
   input  logic                 clk,
   input  logic                 sync_reset_n,
   input  logic                 wr_en,
   input  logic [DATA_WDTH-1:0] wr_din,
   input  logic                 rd_en,
   output logic [DATA_WDTH-1:0] rd_dout,
   output logic                 rd_dout_val,
   output logic                 full,
   output logic                 empty,
   output logic                 afull,
   output logic                 aempty,
   output logic [ADDR_WDTH:0]   fill_cnt,
   input  logic                 err_clr,
   output logic                 ovf,
   output logic                 udf
);

   localparam int unsigned          DEPTH     = 2 ** ADDR_WDTH;
   localparam logic [ADDR_WDTH:0]   DEPTH_C   = DEPTH[ADDR_WDTH:0];
   localparam logic [ADDR_WDTH:0]   AFULL_C   = AFULL_THR[ADDR_WDTH:0];
   localparam logic [ADDR_WDTH:0]   AEMPTY_C  = AEMPTY_THR[ADDR_WDTH:0];
   localparam logic [ADDR_WDTH-1:0] PTR_ONE   = 1;
   localparam logic [ADDR_WDTH:0]   CNT_ONE   = 1;

   (* ram_style = "block" *) logic [DATA_WDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WDTH:0]   cnt_q, cnt_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic                 afull_q, afull_d;
   logic                 aempty_q, aempty_d;
   logic                 rd_val_q, rd_val_d;
   logic [DATA_WDTH-1:0] rd_dout_q;
   logic                 ovf_q, ovf_d;
   logic                 udf_q, udf_d;
   logic                 wr_acc, rd_acc;

   // Acceptance uses the registered flags, so full+rd+wr drains only and
   // empty+rd+wr fills only: no write-through or fall-through paths.
   assign wr_acc = wr_en & ~full_q;
   assign rd_acc = rd_en & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      full_d   = (cnt_d == DEPTH_C);
      empty_d  = (cnt_d == '0);
      afull_d  = (cnt_d >= AFULL_C);
      aempty_d = (cnt_d <= AEMPTY_C);
      rd_val_d = rd_acc;
   end

`ifdef DPBUF_FIFO_ERR_FLAGS_EN
   always_comb begin
      ovf_d = ovf_q | (wr_en & full_q);
      udf_d = udf_q | (rd_en & empty_q);
      if (err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;

   always_comb begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         rd_val_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         rd_val_q <= rd_val_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage has no reset; writes are still suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (sync_reset_n && wr_acc) begin
         mem_q[wr_ptr_q] <= wr_din;
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         rd_dout_q <= '0;
      end else if (rd_acc) begin
         rd_dout_q <= mem_q[rd_ptr_q];
      end
   end

   assign rd_dout     = rd_dout_q;
   assign rd_dout_val = rd_val_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign afull       = afull_q;
   assign aempty      = aempty_q;
   assign fill_cnt    = cnt_q;
   assign ovf         = ovf_q;
   assign udf         = udf_q;

endmodule

// File: tb/tb_dpbuf_fifo.sv
// Self-checking bench for dpbuf_fifo: constant vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_dpbuf_fifo;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AFT   = 14;
   localparam int AET   = 2;

   logic          clk = 1'b0;
   logic          sync_reset_n;
   logic          wr_en;
   logic [DW-1:0] wr_din;
   logic          rd_en;
   logic [DW-1:0] rd_dout;
   logic          rd_dout_val;
   logic          full, empty, afull, aempty;
   logic [AW:0]   fill_cnt;
   logic          err_clr;
   logic          ovf, udf;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dout;
   logic          m_val, m_ovf, m_udf;
   bit            err_en;

   always #5 clk = ~clk;

   dpbuf_fifo #(
      .ADDR_WDTH (AW),
      .DATA_WDTH (DW),
      .AFULL_THR (AFT),
      .AEMPTY_THR(AET)
   ) dut (
      .clk         (clk),
      .sync_reset_n(sync_reset_n),
      .wr_en       (wr_en),
      .wr_din      (wr_din),
      .rd_en       (rd_en),
      .rd_dout     (rd_dout),
      .rd_dout_val (rd_dout_val),
      .full        (full),
      .empty       (empty),
      .afull       (afull),
      .aempty      (aempty),
      .fill_cnt    (fill_cnt),
      .err_clr     (err_clr),
      .ovf         (ovf),
      .udf         (udf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO as a queue whose size is the occupancy.
   task automatic model_edge(input bit rst_n, input bit w, input logic [DW-1:0] d,
                             input bit r, input bit clr);
      bit wa, ra;
      if (!rst_n) begin
         mq.delete();
         m_dout = '0;
         m_val  = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         wa = w && (mq.size() < DEPTH);
         ra = r && (mq.size() > 0);
         m_val = ra;
         if (ra) m_dout = mq.pop_front();
         if (wa) mq.push_back(d);
         if (err_en) begin
            m_ovf = clr ? 1'b0 : (m_ovf | (w && !wa));
            m_udf = clr ? 1'b0 : (m_udf | (r && !ra));
         end
      end
   endtask

   task automatic check_all();
      int sz;
      sz = mq.size();
      chk("fill_cnt", 32'(fill_cnt), 32'(sz));
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("afull", 32'(afull), 32'(sz >= AFT));
      chk("aempty", 32'(aempty), 32'(sz <= AET));
      chk("rd_dout_val", 32'(rd_dout_val), 32'(m_val));
      chk("rd_dout", 32'(rd_dout), 32'(m_dout));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("udf", 32'(udf), 32'(m_udf));
   endtask

   task automatic step(input bit rst_n, input bit w, input logic [DW-1:0] d,
                       input bit r, input bit clr);
      sync_reset_n = rst_n;
      wr_en        = w;
      wr_din       = d;
      rd_en        = r;
      err_clr      = clr;
      @(posedge clk);
      model_edge(rst_n, w, d, r, clr);
      #1;
      check_all();
   endtask

   typedef struct {
      bit            rst_n;
      bit            w;
      logic [DW-1:0] d;
      bit            r;
      int            e_cnt;
      bit            e_val;
      logic [DW-1:0] e_dout;
   } vec_t;

   vec_t vt[10];

   initial begin
`ifdef DPBUF_FIFO_ERR_FLAGS_EN
      err_en = 1'b1;
`else
      err_en = 1'b0;
`endif
      sync_reset_n = 1'b0;
      wr_en = 1'b0; wr_din = '0; rd_en = 1'b0; err_clr = 1'b0;
      m_dout = '0; m_val = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

      vt[0] = '{0, 0, 8'h00, 0, 0, 0, 8'h00};
      vt[1] = '{1, 1, 8'h11, 0, 1, 0, 8'h00};
      vt[2] = '{1, 1, 8'h22, 0, 2, 0, 8'h00};
      vt[3] = '{1, 0, 8'h00, 1, 1, 1, 8'h11};
      vt[4] = '{1, 1, 8'h33, 1, 1, 1, 8'h22};
      vt[5] = '{1, 0, 8'h00, 0, 1, 0, 8'h22};
      vt[6] = '{1, 0, 8'h00, 1, 0, 1, 8'h33};
      vt[7] = '{1, 0, 8'h00, 1, 0, 0, 8'h33};
      vt[8] = '{1, 1, 8'h44, 1, 1, 0, 8'h33};
      vt[9] = '{1, 0, 8'h00, 1, 0, 1, 8'h44};

      for (int i = 0; i < 10; i++) begin
         step(vt[i].rst_n, vt[i].w, vt[i].d, vt[i].r, 1'b0);
         chk($sformatf("vec%0d_cnt", i), 32'(fill_cnt), 32'(vt[i].e_cnt));
         chk($sformatf("vec%0d_val", i), 32'(rd_dout_val), 32'(vt[i].e_val));
         chk($sformatf("vec%0d_dout", i), 32'(rd_dout), 32'(vt[i].e_dout));
      end

      // In-order data, one cycle latency, flags stepped 0..16 on fill.
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(i), 0, 0);
      chk("fill16_full", 32'(full), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 0, 1, 0);
         chk("order_val", 32'(rd_dout_val), 32'd1);
         chk("order_data", 32'(rd_dout), 32'(i));
      end
      chk("drained_empty", 32'(empty), 32'd1);

      // Overflow on full, err_clr, and rejected data never appears.
      for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(8'h50 + i), 0, 0);
      step(1, 1, 8'hAA, 0, 0);
      chk("ovf_cnt", 32'(fill_cnt), 32'd16);
      chk("ovf_flag", 32'(ovf), 32'(err_en));
      step(1, 1, 8'hAB, 1, 0);
      chk("full_rw_dout", 32'(rd_dout), 32'h50);
      chk("full_rw_cnt", 32'(fill_cnt), 32'd15);
      step(1, 0, 0, 0, 1);
      chk("ovf_cleared", 32'(ovf), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0, 1, 0);
      chk("ovf_last_data", 32'(rd_dout), 32'h5F);

      // Underflow on empty read.
      step(1, 0, 0, 1, 0);
      chk("udf_val", 32'(rd_dout_val), 32'd0);
      chk("udf_flag", 32'(udf), 32'(err_en));
      step(1, 0, 0, 0, 1);

      // Steady occupancy of 8 with simultaneous traffic across pointer wraps.
      for (int i = 0; i < 8; i++) step(1, 1, 8'(8'hC0 + i), 0, 0);
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 8'(8'hC8 + i), 1, 0);
         chk("wrap_cnt", 32'(fill_cnt), 32'd8);
         chk("wrap_data", 32'(rd_dout), 32'(8'(8'hC0 + i)));
      end

      // Reset right after an accepted read at occupancy 5.
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 8'(i + 1), 0, 0);
      step(1, 0, 0, 1, 0);
      chk("pre_rst_val", 32'(rd_dout_val), 32'd1);
      step(0, 1, 8'h77, 1, 0);
      chk("rst_val", 32'(rd_dout_val), 32'd0);
      chk("rst_cnt", 32'(fill_cnt), 32'd0);
      chk("rst_dout", 32'(rd_dout), 32'd0);
      step(1, 0, 0, 0, 0);
      chk("post_rst_val", 32'(rd_dout_val), 32'd0);

      // Randomized traffic with occasional clear and reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 99) < 55),
              8'($urandom),
              ($urandom_range(0, 99) < 50),
              ($urandom_range(0, 29) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dpbuf_fifo.md
DPBUF_FIFO -- requirements
Module: dpbuf_fifo

Interface
REQ-001 SHALL have parameter ADDR_WDTH, default 4, log2 of depth; DEPTH = 2**ADDR_WDTH entries.
REQ-002 SHALL have parameter DATA_WDTH, default 8, data width in bits.
REQ-003 SHALL have parameter AFULL_THR, default DEPTH-2, almost-full threshold in entries, legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_THR, default 2, almost-empty threshold in entries, legal range 1..DEPTH-1.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-006 SHALL have port sync_reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_din, input, DATA_WDTH, write data.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port rd_dout, output, DATA_WDTH, read data.
REQ-011 SHALL have port rd_dout_val, output, 1, rd_dout valid strobe.
REQ-012 SHALL have ports full, empty, afull and aempty, each output, 1, status flags.
REQ-013 SHALL have port fill_cnt, output, ADDR_WDTH+1, occupancy 0..DEPTH.
REQ-014 SHALL have port err_clr, input, 1, clears the sticky error flags.
REQ-015 SHALL have ports ovf and udf, each output, 1, sticky overflow and underflow flags.

Function
REQ-016 SHALL store data in a block-RAM-style array (ram_style "block"), synchronous write and registered read, contents not reset.
REQ-017 SHALL accept a write only when wr_en=1 and full=0; the write goes to wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-018 SHALL accept a read only when rd_en=1 and empty=0; data comes from rd_ptr, and rd_ptr increments modulo DEPTH.
REQ-019 SHALL assert rd_dout_val exactly 1 cycle after an accepted read, with rd_dout valid in that cycle; rd_dout holds its last value otherwise.
REQ-020 SHALL update fill_cnt in the cycle after the request: +1 on write only, -1 on read only, unchanged when both are accepted together.
REQ-021 SHALL register full (fill_cnt==DEPTH), empty (fill_cnt==0), afull (fill_cnt>=AFULL_THR) and aempty (fill_cnt<=AEMPTY_THR), all consistent with fill_cnt in the same cycle.
REQ-022 SHALL, when full and wr_en and rd_en are asserted together, accept the read and reject the write (no write-through).
REQ-023 SHALL, when empty and wr_en and rd_en are asserted together, accept the write and reject the read (no fall-through); rd_dout_val stays 0 in the next cycle.
REQ-024 SHALL wrap pointers from DEPTH-1 to 0 without data corruption or flag glitches.
REQ-025 SHALL ignore rejected requests entirely: no pointer, count or memory change.

Reset
REQ-026 SHALL, when sync_reset_n=0 at a clock edge, set wr_ptr=0, rd_ptr=0, fill_cnt=0, empty=1, aempty=1, full=0, afull=0, rd_dout_val=0, ovf=0 and udf=0; rd_dout is set to 0.
REQ-027 SHALL have reset take priority over wr_en, rd_en and err_clr; a read accepted in the cycle before reset produces no rd_dout_val after reset.

Configuration
REQ-028 SHALL gate the error flags with macro DPBUF_FIFO_ERR_FLAGS_EN: when defined, ovf sets on a rejected write, udf sets on a rejected read, and both hold until err_clr=1 or reset; err_clr has priority over a same-cycle set.
REQ-029 SHALL, when DPBUF_FIFO_ERR_FLAGS_EN is undefined, tie ovf and udf to 0, ignore err_clr, and keep the port list identical.

Verification
REQ-030 SHALL cover: ADDR_WDTH=4, write 0x00..0x0F, then read 16 -> data 0x00..0x0F in order, each 1 cycle after rd_en; empty=1 at end.
REQ-031 SHALL cover: fill to 16, write 0xAA -> full=1, fill_cnt=16, data not stored; ovf=1 if the macro is defined, else 0; err_clr -> ovf=0.
REQ-032 SHALL cover: empty FIFO with rd_en=1 -> rd_dout_val=0 and fill_cnt=0; udf=1 if the macro is defined.
REQ-033 SHALL cover: fill_cnt=8 with simultaneous wr/rd for 40 cycles (pointer wrap) -> fill_cnt stays 8 and data order is preserved.
REQ-034 SHALL cover: AFULL_THR=14, AEMPTY_THR=2, stepping fill_cnt 0..16 -> aempty=1 for 0..2 and afull=1 for 14..16.
REQ-035 SHALL cover: fill_cnt=5 with an accepted read, then sync_reset_n=0 for 1 cycle -> all outputs at reset values and no rd_dout_val after reset.
